// File: rtl/ahb_apb_arbiter.sv
// Multi-requester AHB master front end for the AHB-to-APB bridge: arbitrates, issues one SINGLE transfer, returns the response.
// Define AHB_APB_ARB_FIXED_PRIO_EN for fixed lowest-index priority; the default build is round-robin.
`ifndef HADDR_SYS_WIDTH
`define HADDR_SYS_WIDTH 32
`endif
`ifndef HSIZE_WIDTH
`define HSIZE_WIDTH 3
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb_apb_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                                 hclk,
    input  logic                                 hreset_n,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ*`HADDR_SYS_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]                   req_write,
    input  logic [NUM_REQ*`HSIZE_WIDTH-1:0]      req_size,
    input  logic [NUM_REQ*`AHB_DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                   gnt,
    output logic [NUM_REQ-1:0]                   done,
    output logic [`AHB_DATA_WIDTH-1:0]           rdata,
    output logic                                 err,
    output logic                                 busy,
    output logic [`HADDR_SYS_WIDTH-1:0]          haddr,
    output logic                                 hsel,
    output logic [1:0]                           htrans,
    output logic                                 hwrite,
    output logic [`HSIZE_WIDTH-1:0]              hsize,
    output logic [2:0]                           hburst,
    output logic [`AHB_DATA_WIDTH-1:0]           hwdata,
    output logic                                 hready,
    input  logic                                 hreadyout,
    input  logic                                 hresp,
    input  logic [`AHB_DATA_WIDTH-1:0]           hrdata
);

    localparam int unsigned AW = `HADDR_SYS_WIDTH;
    localparam int unsigned SW = `HSIZE_WIDTH;
    localparam int unsigned DW = `AHB_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state, state_next;

    logic             any_req;
    logic [2:0]       winner;
    logic [2:0]       owner;
    logic [AW-1:0]    lat_addr;
    logic             lat_write;
    logic [SW-1:0]    lat_size;
    logic [DW-1:0]    lat_wdata;
    logic [AW-1:0]    sel_addr;
    logic             sel_write;
    logic [SW-1:0]    sel_size;
    logic [DW-1:0]    sel_wdata;

    assign any_req = |req;

`ifdef AHB_APB_ARB_FIXED_PRIO_EN
    always_comb begin
        logic [NUM_REQ-1:0] req_sh;
        logic               found;
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_sh = req >> i;
            if (req_sh[0] && !found) begin
                winner = 3'(i);
                found  = 1'b1;
            end
        end
    end
`else
    logic [2:0] ptr;

    // Walk offsets from farthest to nearest so the requester closest after ptr is assigned last.
    always_comb begin
        logic [NUM_REQ-1:0] req_sh;
        int unsigned        idx;
        winner = '0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            idx    = ({29'b0, ptr} + k) % NUM_REQ;
            req_sh = req >> idx;
            if (req_sh[0]) winner = 3'(idx);
        end
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            ptr <= 3'(NUM_REQ - 1);
        end else if (state == IDLE && any_req) begin
            ptr <= winner;
        end
    end
`endif

    always_comb begin
        logic [NUM_REQ-1:0] wr_sh;
        int unsigned        widx;
        widx      = int'(winner);
        wr_sh     = req_write >> widx;
        sel_addr  = AW'(req_addr >> (widx * AW));
        sel_write = wr_sh[0];
        sel_size  = SW'(req_size >> (widx * SW));
        sel_wdata = DW'(req_wdata >> (widx * DW));
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (any_req)   state_next = ADDR;
            ADDR:    if (hreadyout) state_next = DATA;
            DATA:    if (hreadyout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            owner     <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_size  <= '0;
            lat_wdata <= '0;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            gnt   <= '0;
            done  <= '0;
            rdata <= '0;
            err   <= 1'b0;
            if (state == IDLE && any_req) begin
                owner     <= winner;
                lat_addr  <= sel_addr;
                lat_write <= sel_write;
                lat_size  <= sel_size;
                lat_wdata <= sel_wdata;
                gnt       <= NUM_REQ'(1) << winner;
            end
            if (state == DATA && hreadyout) begin
                rdata <= hrdata;
                err   <= hresp;
                done  <= NUM_REQ'(1) << owner;
            end
        end
    end

    // Bus outputs decode from state so reset clears them in the same edge.
    always_comb begin
        busy   = (state != IDLE);
        hsel   = (state == ADDR);
        htrans = (state == ADDR) ? 2'b10 : 2'b00;
        haddr  = (state == ADDR) ? lat_addr : '0;
        hwrite = (state == ADDR) ? lat_write : 1'b0;
        hsize  = (state == ADDR) ? lat_size : '0;
        hburst = 3'b000;
        hwdata = (state == DATA) ? lat_wdata : '0;
        hready = hreadyout;
    end

endmodule

// File: tb/tb_ahb_apb_arbiter.sv
// Directed self-checking bench for ahb_apb_arbiter; inputs change and outputs are sampled on the falling clock edge.
`ifndef HADDR_SYS_WIDTH
`define HADDR_SYS_WIDTH 32
`endif
`ifndef HSIZE_WIDTH
`define HSIZE_WIDTH 3
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module tb_ahb_apb_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = `HADDR_SYS_WIDTH;
    localparam int unsigned SW = `HSIZE_WIDTH;
    localparam int unsigned DW = `AHB_DATA_WIDTH;

    logic              hclk = 1'b0;
    logic              hreset_n;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_write;
    logic [N*SW-1:0]   req_size;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      gnt, done;
    logic [DW-1:0]     rdata;
    logic              err, busy;
    logic [AW-1:0]     haddr;
    logic              hsel;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [SW-1:0]     hsize;
    logic [2:0]        hburst;
    logic [DW-1:0]     hwdata;
    logic              hready;
    logic              hreadyout, hresp;
    logic [DW-1:0]     hrdata;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 hclk = ~hclk;

    ahb_apb_arbiter #(.NUM_REQ(N)) dut (
        .hclk(hclk), .hreset_n(hreset_n), .req(req), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .err(err), .busy(busy),
        .haddr(haddr), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata)
    );

    task automatic set_payload(input int unsigned r, input logic [AW-1:0] a,
                               input logic w, input logic [DW-1:0] d);
        req_addr[r*AW +: AW]  = a;
        req_write[r]          = w;
        req_size[r*SW +: SW]  = SW'(2);
        req_wdata[r*DW +: DW] = d;
    endtask

    task automatic test_reset();
        hreset_n = 1'b0; req = '0; hreadyout = 1'b1; hresp = 1'b0; hrdata = '0;
        req_addr = '0; req_write = '0; req_size = '0; req_wdata = '0;
        repeat (2) @(negedge hclk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (gnt !== '0 || done !== '0) begin n_bad++; $display("FAIL rst_pulses got gnt=%b done=%b want 0", gnt, done); end
        n_cmp++; if (rdata !== '0 || err !== 1'b0) begin n_bad++; $display("FAIL rst_resp got rdata=%h err=%b want 0", rdata, err); end
        n_cmp++; if (hsel !== 1'b0 || htrans !== 2'b00 || haddr !== '0 || hwdata !== '0) begin
            n_bad++; $display("FAIL rst_bus got hsel=%b htrans=%b haddr=%h hwdata=%h want 0", hsel, htrans, haddr, hwdata); end
        hreadyout = 1'b0; #1;
        n_cmp++; if (hready !== 1'b0) begin n_bad++; $display("FAIL hready_lo got %b want 0", hready); end
        hreadyout = 1'b1; #1;
        n_cmp++; if (hready !== 1'b1) begin n_bad++; $display("FAIL hready_hi got %b want 1", hready); end
        hreset_n = 1'b1;
        @(negedge hclk);
        n_cmp++; if (busy !== 1'b0 || gnt !== '0) begin n_bad++; $display("FAIL idle_noreq got busy=%b gnt=%b want 0", busy, gnt); end
    endtask

    task automatic test_contention();
        int unsigned got[$];
        int unsigned expv[$];
        int unsigned cyc, last, idx, want_n;
`ifdef AHB_APB_ARB_FIXED_PRIO_EN
        expv = '{0, 0, 0};
`else
        expv = '{0, 1, 2, 3, 0};
`endif
        want_n = expv.size();
        for (int unsigned i = 0; i < N; i++) set_payload(i, AW'(32'h100 * (i + 1)), 1'b0, '0);
        hreadyout = 1'b1; req = '1; cyc = 0; last = 0;
        while (got.size() < want_n && cyc < 40) begin
            @(negedge hclk); cyc++;
            if (gnt !== '0) begin
                idx = 0;
                for (int unsigned b = 0; b < N; b++) if (gnt[b]) idx = b;
                n_cmp++; if (!$onehot(gnt)) begin n_bad++; $display("FAIL cont_onehot got %b want one-hot", gnt); end
                n_cmp++; if (haddr !== AW'(32'h100 * (idx + 1))) begin
                    n_bad++; $display("FAIL cont_haddr got %h want %h", haddr, 32'h100 * (idx + 1)); end
                n_cmp++; if (cyc - last != ((got.size() == 0) ? 1 : 3)) begin
                    n_bad++; $display("FAIL cont_spacing got %0d want %0d", cyc - last, (got.size() == 0) ? 1 : 3); end
                got.push_back(idx); last = cyc;
            end
        end
        req = '0;
        n_cmp++; if (got.size() != want_n) begin n_bad++; $display("FAIL cont_timeout got %0d grants want %0d", got.size(), want_n); end
        for (int unsigned k = 0; k < got.size() && k < want_n; k++) begin
            n_cmp++; if (got[k] != expv[k]) begin n_bad++; $display("FAIL cont_order[%0d] got %0d want %0d", k, got[k], expv[k]); end
        end
        repeat (3) @(negedge hclk);
    endtask

    task automatic test_single_write();
        set_payload(0, AW'(32'h0000_1004), 1'b1, DW'(32'hA5A5_0001));
        hreadyout = 1'b1; hresp = 1'b0; req = 4'b0001;
        @(negedge hclk);
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL sw_gnt got %b want 0001", gnt); end
        n_cmp++; if (htrans !== 2'b10 || hsel !== 1'b1 || hburst !== 3'b000) begin
            n_bad++; $display("FAIL sw_ctrl got htrans=%b hsel=%b hburst=%b want 10/1/000", htrans, hsel, hburst); end
        n_cmp++; if (haddr !== AW'(32'h1004) || hwrite !== 1'b1 || hsize !== SW'(2)) begin
            n_bad++; $display("FAIL sw_addr got haddr=%h hwrite=%b hsize=%0d want 1004/1/2", haddr, hwrite, hsize); end
        req = '0;
        @(negedge hclk);
        n_cmp++; if (hwdata !== DW'(32'hA5A5_0001) || hsel !== 1'b0 || htrans !== 2'b00) begin
            n_bad++; $display("FAIL sw_data got hwdata=%h hsel=%b htrans=%b want a5a50001/0/00", hwdata, hsel, htrans); end
        n_cmp++; if (gnt !== '0 || done !== '0) begin n_bad++; $display("FAIL sw_midpulse got gnt=%b done=%b want 0", gnt, done); end
        @(negedge hclk);
        n_cmp++; if (done !== 4'b0001 || err !== 1'b0) begin n_bad++; $display("FAIL sw_done got done=%b err=%b want 0001/0", done, err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sw_idle got busy=%b want 0", busy); end
        @(negedge hclk);
        n_cmp++; if (done !== '0) begin n_bad++; $display("FAIL sw_done_clear got %b want 0", done); end
    endtask

    task automatic test_wait_read();
        set_payload(1, AW'(32'h0000_2000), 1'b0, '0);
        hreadyout = 1'b1; hrdata = DW'(32'h1234_5678); req = 4'b0010;
        @(negedge hclk);
        n_cmp++; if (gnt !== 4'b0010 || haddr !== AW'(32'h2000) || hwrite !== 1'b0) begin
            n_bad++; $display("FAIL wr_addr got gnt=%b haddr=%h hwrite=%b want 0010/2000/0", gnt, haddr, hwrite); end
        req = '0;
        for (int j = 0; j < 4; j++) begin
            @(negedge hclk);
            n_cmp++; if (done !== '0 || rdata !== '0 || busy !== 1'b1 || htrans !== 2'b00) begin
                n_bad++; $display("FAIL wr_wait%0d got done=%b rdata=%h busy=%b htrans=%b want 0/0/1/00", j, done, rdata, busy, htrans); end
            hreadyout = 1'b0;
        end
        @(negedge hclk);
        n_cmp++; if (done !== '0) begin n_bad++; $display("FAIL wr_early got %b want 0", done); end
        hreadyout = 1'b1;
        @(negedge hclk);
        n_cmp++; if (done !== 4'b0010 || rdata !== DW'(32'h1234_5678) || err !== 1'b0) begin
            n_bad++; $display("FAIL wr_done got done=%b rdata=%h err=%b want 0010/12345678/0", done, rdata, err); end
        @(negedge hclk);
        n_cmp++; if (rdata !== '0) begin n_bad++; $display("FAIL wr_rdata_clear got %h want 0", rdata); end
    endtask

    task automatic test_error();
        set_payload(2, AW'(32'h0000_3008), 1'b1, DW'(32'hDEAD_0002));
        hreadyout = 1'b0; hresp = 1'b0; req = 4'b0100;
        @(negedge hclk);
        n_cmp++; if (gnt !== 4'b0100 || haddr !== AW'(32'h3008)) begin
            n_bad++; $display("FAIL er_gnt got gnt=%b haddr=%h want 0100/3008", gnt, haddr); end
        req = '0;
        @(negedge hclk);
        n_cmp++; if (haddr !== AW'(32'h3008) || htrans !== 2'b10 || hsel !== 1'b1 || gnt !== '0) begin
            n_bad++; $display("FAIL er_addr_hold got haddr=%h htrans=%b hsel=%b gnt=%b want 3008/10/1/0", haddr, htrans, hsel, gnt); end
        hreadyout = 1'b1;
        @(negedge hclk);
        hreadyout = 1'b0; hresp = 1'b1;
        @(negedge hclk);
        n_cmp++; if (done !== '0 || busy !== 1'b1) begin n_bad++; $display("FAIL er_wait got done=%b busy=%b want 0/1", done, busy); end
        hreadyout = 1'b1;
        @(negedge hclk);
        n_cmp++; if (done !== 4'b0100 || err !== 1'b1) begin n_bad++; $display("FAIL er_done got done=%b err=%b want 0100/1", done, err); end
        hresp = 1'b0;
        set_payload(3, AW'(32'h0000_4000), 1'b0, '0);
        req = 4'b1000;
        @(negedge hclk);
        n_cmp++; if (gnt !== 4'b1000 || err !== 1'b0) begin n_bad++; $display("FAIL er_next_gnt got gnt=%b err=%b want 1000/0", gnt, err); end
        req = '0;
        repeat (2) @(negedge hclk);
        n_cmp++; if (done !== 4'b1000 || err !== 1'b0) begin n_bad++; $display("FAIL er_next_done got done=%b err=%b want 1000/0", done, err); end
        @(negedge hclk);
    endtask

    task automatic test_reset_mid_data();
        set_payload(1, AW'(32'h0000_5000), 1'b1, DW'(32'h0BAD_F00D));
        hreadyout = 1'b1; req = 4'b0010;
        @(negedge hclk);
        req = '0;
        @(negedge hclk);
        n_cmp++; if (hwdata !== DW'(32'h0BAD_F00D)) begin n_bad++; $display("FAIL rm_data got %h want 0badf00d", hwdata); end
        hreadyout = 1'b0; hreset_n = 1'b0;
        @(negedge hclk);
        n_cmp++; if (done !== '0 || busy !== 1'b0 || gnt !== '0 || rdata !== '0 || err !== 1'b0) begin
            n_bad++; $display("FAIL rm_outs got done=%b busy=%b gnt=%b rdata=%h err=%b want 0", done, busy, gnt, rdata, err); end
        n_cmp++; if (hsel !== 1'b0 || htrans !== 2'b00 || haddr !== '0 || hwdata !== '0 || hready !== 1'b0) begin
            n_bad++; $display("FAIL rm_bus got hsel=%b htrans=%b haddr=%h hwdata=%h hready=%b want 0", hsel, htrans, haddr, hwdata, hready); end
        hreset_n = 1'b1; hreadyout = 1'b1;
        @(negedge hclk);
        n_cmp++; if (done !== '0) begin n_bad++; $display("FAIL rm_late_done got %b want 0", done); end
        req = '1;
        @(negedge hclk);
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rm_first_win got %b want 0001", gnt); end
        req = '0;
        repeat (3) @(negedge hclk);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_write();
        test_wait_read();
        test_error();
        test_reset_mid_data();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
